accum_warp_looper: RTL and testbench

// - Stage directly downstream of the accumulation block looper.
// - Consumes one accumulation-block offset (abofs) per rdy/ack transaction.
// - Walks that block in warp-sized steps over N_DIM nested loops, innermost = dim 0.
// - Emits one warp offset per cycle to the fetch/ALU side, tagged with a last-warp flag.
// - Clips partial blocks at the global accumulation end.

---
 rtl/mimori_loop_pkg.sv | 34 +++
 rtl/nd_carry_counter.sv | 50 +++++
 rtl/accum_warp_looper.sv | 104 ++++++++++
 tb/tb_accum_warp_looper.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mimori_loop_pkg.sv
// Shared types for the accumulation loopers.
// Coordinates are unsigned, one DW-bit lane per loop dimension.
package mimori_loop_pkg;

  localparam int N_DIM = 3;
  localparam int DW    = 16;

  typedef logic [DW-1:0] coord_t;
  typedef coord_t [N_DIM-1:0] vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Trip limit of one dim: min(bsize, aend-ofs), 0 once past the end
  function automatic coord_t clip_lim(
    input coord_t ofs,
    input coord_t bsize,
    input coord_t aend
  );
    logic [DW:0] room;
    coord_t      res;
    room = {1'b0, aend} - {1'b0, ofs};
    if (ofs >= aend)
      res = '0;
    else if ({1'b0, bsize} < room)
      res = bsize;
    else
      res = room[DW-1:0];
    return res;
  endfunction

endpackage

// File: rtl/nd_carry_counter.sv
// N-dim local counter with a carry chain, dim 0 innermost.
// all_last flags the final position of the nest.
module nd_carry_counter
  import mimori_loop_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  vec_t lim,
  input  vec_t step,
  input  logic inc,
  input  logic clear,
  output vec_t cnt,
  output logic all_last
);

  vec_t        cnt_nxt;
  logic [DW:0] sum [N_DIM];
  logic        carry;

  // Ripple the increment up the dims, wrapping each at its limit
  always_comb begin
    cnt_nxt  = cnt;
    all_last = 1'b1;
    carry    = inc;
    for (int d = 0; d < N_DIM; d++) begin
      sum[d] = {1'b0, cnt[d]} + {1'b0, step[d]};
      if (sum[d] < {1'b0, lim[d]})
        all_last = 1'b0;
      if (carry) begin
        if (sum[d] >= {1'b0, lim[d]}) begin
          cnt_nxt[d] = '0;
        end else begin
          cnt_nxt[d] = sum[d][DW-1:0];
          carry      = 1'b0;
        end
      end
    end
  end

  // Counter register, cleared at block start and end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/accum_warp_looper.sv
// Walks one accumulation block in warp steps.
// Emits one clipped warp offset per accepted beat.
module accum_warp_looper
  import mimori_loop_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  src_rdy,
  output logic                  src_ack,
  input  logic [N_DIM*DW-1:0]   src_abofs,
  input  logic [N_DIM*DW-1:0]   cfg_bsize,
  input  logic [N_DIM*DW-1:0]   cfg_aend,
  input  logic [N_DIM*DW-1:0]   cfg_step,
  output logic                  dst_rdy,
  input  logic                  dst_ack,
  output logic [N_DIM*DW-1:0]   dst_wofs,
  output logic                  dst_last
);

  state_t state, state_nxt;
  vec_t   src_v, bsize_v, aend_v, stp_v;
  vec_t   abofs_q, lim_q, lim_new;
  vec_t   step_eff, cnt, wofs;
  logic   zero_trip, inc, clear, all_last;

  assign src_v   = src_abofs;
  assign bsize_v = cfg_bsize;
  assign aend_v  = cfg_aend;
  assign stp_v   = cfg_step;

  // Clipped limits of the offered block and effective steps
  always_comb begin
    zero_trip = 1'b0;
    lim_new   = '0;
    step_eff  = '0;
    for (int d = 0; d < N_DIM; d++) begin
      lim_new[d] = clip_lim(src_v[d], bsize_v[d], aend_v[d]);
      step_eff[d] = (stp_v[d] == '0) ? coord_t'(1) : stp_v[d];
      if (lim_new[d] == '0)
        zero_trip = 1'b1;
    end
  end

  assign src_ack = src_rdy && i_rst && (state == IDLE);
  assign dst_rdy = (state == BUSY);
  assign inc     = dst_rdy && dst_ack;
  assign clear   = src_ack || (inc && all_last);

  // Next state: enter BUSY on a non-empty block, leave on last beat
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == IDLE:
        if (src_ack && !zero_trip)
          state_nxt = BUSY;
      state == BUSY:
        if (inc && all_last)
          state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Block origin and limits captured on acceptance
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      abofs_q <= '0;
      lim_q   <= '0;
    end else if (src_ack) begin
      abofs_q <= src_v;
      lim_q   <= lim_new;
    end
  end

  nd_carry_counter u_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .lim      (lim_q),
    .step     (step_eff),
    .inc      (inc),
    .clear    (clear),
    .cnt      (cnt),
    .all_last (all_last)
  );

  // Warp offset = block origin + local counter
  always_comb begin
    wofs = '0;
    for (int d = 0; d < N_DIM; d++)
      wofs[d] = abofs_q[d] + cnt[d];
  end

  assign dst_wofs = wofs;
  assign dst_last = dst_rdy && all_last;

endmodule

// File: tb/tb_accum_warp_looper.sv
// Directed bench for accum_warp_looper.
// Expected beats are hand-computed per block.
module tb_accum_warp_looper;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        src_rdy;
  logic        src_ack;
  logic [47:0] src_abofs;
  logic [47:0] cfg_bsize;
  logic [47:0] cfg_aend;
  logic [47:0] cfg_step;
  logic        dst_rdy;
  logic        dst_ack;
  logic [47:0] dst_wofs;
  logic        dst_last;

  int n_chk  = 0;
  int n_pass = 0;

  logic [47:0] ew [8];

  accum_warp_looper dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .src_rdy   (src_rdy),
    .src_ack   (src_ack),
    .src_abofs (src_abofs),
    .cfg_bsize (cfg_bsize),
    .cfg_aend  (cfg_aend),
    .cfg_step  (cfg_step),
    .dst_rdy   (dst_rdy),
    .dst_ack   (dst_ack),
    .dst_wofs  (dst_wofs),
    .dst_last  (dst_last)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [47:0] v(
    input int x, input int y, input int z
  );
    logic [15:0] a, b, c;
    a = x[15:0];
    b = y[15:0];
    c = z[15:0];
    return {c, b, a};
  endfunction

  task automatic check(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Present one block at a negedge; it must be taken at once
  task automatic send(
    input logic [47:0] a,
    input logic [47:0] b,
    input logic [47:0] e,
    input logic [47:0] s
  );
    src_abofs = a;
    cfg_bsize = b;
    cfg_aend  = e;
    cfg_step  = s;
    src_rdy   = 1'b1;
    #1 check("src_ack", {63'd0, src_ack}, 64'd1);
    @(negedge i_clk);
    src_rdy = 1'b0;
  endtask

  // Consume n_stop beats of an n_tot-beat block against ew[]
  task automatic drain(
    input int n_stop,
    input int n_tot,
    input int pct,
    input string tag
  );
    int          idx = 0;
    int          cyc = 0;
    logic        held = 1'b0;
    logic [47:0] hw = '0;
    logic        ack;
    while (idx < n_stop && cyc < 200) begin
      if (dst_rdy) begin
        if (held)
          check({tag, "_stable"}, {16'd0, dst_wofs}, {16'd0, hw});
        ack = ($urandom_range(99) < pct);
        dst_ack = ack;
        if (ack) begin
          check($sformatf("%s_w%0d", tag, idx),
                {16'd0, dst_wofs}, {16'd0, ew[idx]});
          check($sformatf("%s_l%0d", tag, idx),
                {63'd0, dst_last}, {63'd0, idx == n_tot - 1});
          idx++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hw   = dst_wofs;
        end
      end else begin
        dst_ack = 1'b0;
      end
      @(negedge i_clk);
      cyc++;
    end
    dst_ack = 1'b0;
    if (idx < n_stop)
      check({tag, "_timeout"}, 64'(idx), 64'(n_stop));
  endtask

  task automatic set_t1(input int bx, input int by);
    ew[0] = v(bx,     by,     0);
    ew[1] = v(bx + 2, by,     0);
    ew[2] = v(bx,     by + 1, 0);
    ew[3] = v(bx + 2, by + 1, 0);
  endtask

  logic [47:0] bs1, ae1, st1;

  initial begin
    bs1 = v(4, 2, 1);
    ae1 = v(100, 100, 100);
    st1 = v(2, 1, 1);
    i_rst = 1'b0;
    src_rdy = 1'b0;
    dst_ack = 1'b0;
    src_abofs = '0;
    cfg_bsize = '0;
    cfg_aend = '0;
    cfg_step = '0;
    repeat (2) @(negedge i_clk);
    check("rst_rdy",  {63'd0, dst_rdy},  64'd0);
    check("rst_last", {63'd0, dst_last}, 64'd0);
    check("rst_ack",  {63'd0, src_ack},  64'd0);
    check("rst_wofs", {16'd0, dst_wofs}, 64'd0);
    i_rst = 1'b1;
    @(negedge i_clk);

    // Basic 2-D walk
    set_t1(0, 0);
    send(v(0, 0, 0), bs1, ae1, st1);
    drain(4, 4, 100, "t1");
    check("t1_idle", {63'd0, dst_rdy}, 64'd0);

    // Clipping at aend, zero step on dim 2 counts as 1
    ew[0] = v(6, 0, 0);
    ew[1] = v(7, 0, 0);
    send(v(6, 0, 0), v(4, 2, 1), v(8, 1, 100), v(1, 1, 0));
    drain(2, 2, 100, "t2");
    check("t2_idle", {63'd0, dst_rdy}, 64'd0);

    // Zero-trip block, then next block taken right away
    send(v(8, 0, 0), bs1, v(8, 4, 100), st1);
    check("t3_norise", {63'd0, dst_rdy}, 64'd0);
    set_t1(0, 0);
    send(v(0, 0, 0), bs1, ae1, st1);
    drain(4, 4, 100, "t3");

    // Random backpressure
    set_t1(0, 0);
    send(v(0, 0, 0), bs1, ae1, st1);
    drain(4, 4, 50, "t4");
    check("t4_idle", {63'd0, dst_rdy}, 64'd0);

    // Back-to-back with src_rdy held through the first block
    set_t1(0, 0);
    send(v(0, 0, 0), bs1, ae1, st1);
    src_abofs = v(10, 20, 0);
    src_rdy = 1'b1;
    #1 check("t5_busy_ack", {63'd0, src_ack}, 64'd0);
    drain(4, 4, 100, "t5a");
    #1 check("t5_ack2", {63'd0, src_ack}, 64'd1);
    @(negedge i_clk);
    src_rdy = 1'b0;
    set_t1(10, 20);
    drain(4, 4, 100, "t5b");

    // Reset mid-block drops the rest
    set_t1(0, 0);
    send(v(0, 0, 0), bs1, ae1, st1);
    drain(2, 4, 100, "t6");
    i_rst = 1'b0;
    #1 check("t6_rdy", {63'd0, dst_rdy}, 64'd0);
    check("t6_wofs", {16'd0, dst_wofs}, 64'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("t6_quiet", {63'd0, dst_rdy}, 64'd0);
    send(v(0, 0, 0), bs1, ae1, st1);
    drain(4, 4, 100, "t6r");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
